// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: registered compare threshold for the PWM comparator.
// Manual stepping from two push-buttons, or an automatic breathing ramp.
// DUTY is only ever written on a PERIOD_END edge, so each PWM period sees a
// stable threshold.
// Optional macro: HOLD_STATES_EN adds dwell states at the ramp extremes.
module pwm_duty_sequencer #(
  parameter int WIDTH            = 8,
  parameter int STEP             = 1,
  parameter int PERIODS_PER_STEP = 2,
  parameter int HOLD_PERIODS     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_period_end,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_btn_up,
  input  logic             i_btn_dn,
  input  logic             i_breathe,
  output logic [WIDTH-1:0] o_duty,
  output logic             o_ramp_dir,
  output logic [2:0]       o_state
);

  localparam logic [2:0] S_MANUAL  = 3'd0;
  localparam logic [2:0] S_RAMP_UP = 3'd1;
  localparam logic [2:0] S_RAMP_DN = 3'd3;
`ifdef HOLD_STATES_EN
  localparam logic [2:0] S_HOLD_HI = 3'd2;
  localparam logic [2:0] S_HOLD_LO = 3'd4;
  localparam logic [2:0] S_TOP     = S_HOLD_HI;  // entered when the up-ramp hits LIMIT
  localparam logic [2:0] S_BOTTOM  = S_HOLD_LO;  // entered when the down-ramp hits 0
`else
  localparam logic [2:0] S_TOP     = S_RAMP_DN;
  localparam logic [2:0] S_BOTTOM  = S_RAMP_UP;
`endif

  // One counter serves both step pacing and dwell timing.
  localparam int CNT_MAX = (PERIODS_PER_STEP > HOLD_PERIODS) ? PERIODS_PER_STEP : HOLD_PERIODS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(PERIODS_PER_STEP - 1);
`ifdef HOLD_STATES_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_PERIODS - 1);
`endif
  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

  logic [2:0]       r_up_sync, r_dn_sync;
  logic [2:0]       r_state, w_state_next;
  logic [WIDTH-1:0] r_duty, w_duty_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_pend_up, r_pend_dn, w_pend_up_next, w_pend_dn_next;

  logic             w_up_edge, w_dn_edge;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_up_sat, w_dn_sat, w_ramp_up_val, w_ramp_dn_val;
  logic             w_clamp, w_step_tick, w_is_ramp;

  // Two-flop synchronizers plus a history flop for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_up_sync <= '0;
      r_dn_sync <= '0;
    end else begin
      r_up_sync <= {r_up_sync[1:0], i_btn_up};
      r_dn_sync <= {r_dn_sync[1:0], i_btn_dn};
    end
  end

  assign w_up_edge = r_up_sync[1] & ~r_up_sync[2];
  assign w_dn_edge = r_dn_sync[1] & ~r_dn_sync[2];

  // Saturating step arithmetic carried one bit wider so nothing wraps.
  assign w_sum         = {1'b0, r_duty} + STEP_W;
  assign w_diff        = {1'b0, r_duty} - STEP_W;
  assign w_up_sat      = (w_sum > {1'b0, i_limit}) ? i_limit : w_sum[WIDTH-1:0];
  assign w_dn_sat      = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
  assign w_clamp       = (i_limit < r_duty);
  assign w_ramp_up_val = w_clamp ? i_limit : w_up_sat;
  assign w_ramp_dn_val = w_clamp ? i_limit : w_dn_sat;
  assign w_step_tick   = (r_cnt == STEP_LAST);
  assign w_is_ramp     = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DN);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_MANUAL;
    else          r_state <= w_state_next;
  end

  // Next-state logic; legal transitions happen only at PERIOD_END.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_MANUAL: begin
        if (i_period_end && i_breathe) w_state_next = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (i_period_end) begin
          if (!i_breathe) w_state_next = S_MANUAL;
          else if (w_step_tick && (w_ramp_up_val == i_limit)) w_state_next = S_TOP;
        end
      end
      S_RAMP_DN: begin
        if (i_period_end) begin
          if (!i_breathe) w_state_next = S_MANUAL;
          else if (w_step_tick && (w_ramp_dn_val == '0)) w_state_next = S_BOTTOM;
        end
      end
`ifdef HOLD_STATES_EN
      S_HOLD_HI: begin
        if (i_period_end) begin
          if (!i_breathe) w_state_next = S_MANUAL;
          else if (r_cnt == HOLD_LAST) w_state_next = S_RAMP_DN;
        end
      end
      S_HOLD_LO: begin
        if (i_period_end) begin
          if (!i_breathe) w_state_next = S_MANUAL;
          else if (r_cnt == HOLD_LAST) w_state_next = S_RAMP_UP;
        end
      end
`endif
      default: w_state_next = S_MANUAL;  // unused encodings recover immediately
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    o_duty  = r_duty;
    o_state = r_state;
`ifdef HOLD_STATES_EN
    o_ramp_dir = (r_state == S_RAMP_UP) || (r_state == S_HOLD_HI);
`else
    o_ramp_dir = (r_state == S_RAMP_UP);
`endif
  end

  // Next values for DUTY, the period counter and the pending button request.
  always_comb begin
    w_duty_next    = r_duty;
    w_cnt_next     = r_cnt;
    w_pend_up_next = r_pend_up;
    w_pend_dn_next = r_pend_dn;

    if (i_period_end) begin
      if (w_clamp) w_duty_next = i_limit;  // clamp beats any step
      else if (r_state == S_MANUAL) begin
        if (r_pend_up)      w_duty_next = w_up_sat;
        else if (r_pend_dn) w_duty_next = w_dn_sat;
      end else if (i_breathe && w_step_tick) begin
        if (r_state == S_RAMP_UP)      w_duty_next = w_up_sat;
        else if (r_state == S_RAMP_DN) w_duty_next = w_dn_sat;
      end
    end

    // Requests only live in manual mode; the last single-direction edge wins.
    if ((r_state != S_MANUAL) || (w_state_next != S_MANUAL)) begin
      w_pend_up_next = 1'b0;
      w_pend_dn_next = 1'b0;
    end else if (w_up_edge && !w_dn_edge) begin
      w_pend_up_next = 1'b1;
      w_pend_dn_next = 1'b0;
    end else if (w_dn_edge && !w_up_edge) begin
      w_pend_up_next = 1'b0;
      w_pend_dn_next = 1'b1;
    end else if (i_period_end) begin
      w_pend_up_next = 1'b0;  // consumed at this boundary
      w_pend_dn_next = 1'b0;
    end

    if (w_state_next != r_state) w_cnt_next = '0;
    else if (i_period_end && (r_state != S_MANUAL))
      w_cnt_next = (w_is_ramp && w_step_tick) ? '0 : r_cnt + CW'(1);
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty    <= '0;
      r_cnt     <= '0;
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
    end else begin
      r_duty    <= w_duty_next;
      r_cnt     <= w_cnt_next;
      r_pend_up <= w_pend_up_next;
      r_pend_dn <= w_pend_dn_next;
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer. The driver runs a period-level
// reference model and queues the expected outputs after each PERIOD_END;
// the monitor pops them and checks the DUT on every cycle.
`timescale 1ns/1ps
module tb_pwm_duty_sequencer;
  localparam int WIDTH = 8;
  localparam int STEP  = 1;
  localparam int PPS   = 2;
  localparam int HOLD  = 4;
`ifdef HOLD_STATES_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             period_end = 1'b0, btn_up = 1'b0, btn_dn = 1'b0, breathe = 1'b0;
  logic [WIDTH-1:0] limit = '0;
  logic [WIDTH-1:0] duty;
  logic             ramp_dir;
  logic [2:0]       state;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(.WIDTH(WIDTH), .STEP(STEP), .PERIODS_PER_STEP(PPS), .HOLD_PERIODS(HOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_period_end(period_end), .i_limit(limit),
    .i_btn_up(btn_up), .i_btn_dn(btn_dn), .i_breathe(breathe),
    .o_duty(duty), .o_ramp_dir(ramp_dir), .o_state(state)
  );

  typedef struct packed {
    logic [WIDTH-1:0] duty;
    logic [2:0]       st;
    logic             dir;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;

  // Reference model state (period-level, plain integers).
  int m_duty, m_state, m_elapsed, m_pend;
  int g_limit = 0;
  bit g_breathe = 1'b0;
  bit arr_up[int], arr_dn[int];  // cycle index at which a press becomes a request
  int cyc = 0;
  bit prev_up = 1'b0, prev_dn = 1'b0;

  task automatic check(input string name, input exp_t e);
    n_vec++;
    if (duty !== e.duty || state !== e.st || ramp_dir !== e.dir) begin
      n_err++;
      $display("FAIL %s @%0t: got duty=%0d state=%0d dir=%0d, want duty=%0d state=%0d dir=%0d",
               name, $time, duty, state, ramp_dir, e.duty, e.st, e.dir);
    end
  endtask

  function automatic int clampv(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  task automatic model_reset();
    m_duty = 0; m_state = 0; m_elapsed = 0; m_pend = 0;
    arr_up.delete(); arr_dn.delete(); exp_q.delete();
    prev_up = 1'b0; prev_dn = 1'b0;
  endtask

  // Outcome of one clock edge; only PERIOD_END edges change visible outputs.
  task automatic model_step(input bit pe, input bit eu, input bit ed);
    int   ns;
    exp_t e;
    if (!pe) begin
      if (m_state == 0) begin
        if (eu && !ed) m_pend = 1;
        else if (ed && !eu) m_pend = -1;
      end
      return;
    end
    ns = m_state;
    if (m_state == 0) begin
      if (m_duty > g_limit) m_duty = g_limit;
      else if (m_pend > 0) m_duty = (m_duty + STEP > g_limit) ? g_limit : m_duty + STEP;
      else if (m_pend < 0) m_duty = (m_duty < STEP) ? 0 : m_duty - STEP;
      if (g_breathe) begin ns = 1; m_pend = 0; end
      else m_pend = (eu && !ed) ? 1 : ((ed && !eu) ? -1 : 0);
    end else begin
      m_elapsed++;
      if (!g_breathe) begin
        m_duty = clampv(m_duty, g_limit); ns = 0; m_pend = 0;
      end else if (m_state == 1 || m_state == 3) begin
        if (m_elapsed % PPS == 0) begin
          if (m_duty > g_limit) m_duty = g_limit;
          else if (m_state == 1) m_duty = (m_duty + STEP > g_limit) ? g_limit : m_duty + STEP;
          else m_duty = (m_duty < STEP) ? 0 : m_duty - STEP;
          if (m_state == 1 && m_duty == g_limit) ns = HOLD_EN ? 2 : 3;
          if (m_state == 3 && m_duty == 0) ns = HOLD_EN ? 4 : 1;
        end else m_duty = clampv(m_duty, g_limit);
      end else begin
        m_duty = clampv(m_duty, g_limit);
        if (m_elapsed == HOLD) ns = (m_state == 2) ? 3 : 1;
      end
    end
    if (ns != m_state) m_elapsed = 0;
    m_state = ns;
    e.duty = m_duty[WIDTH-1:0];
    e.st   = m_state[2:0];
    e.dir  = (m_state == 1) || (m_state == 2);
    exp_q.push_back(e);
  endtask

  // Drive one cycle at the falling edge and advance the model for the next rising edge.
  task automatic tick(input bit pe, input bit up, input bit dn);
    @(negedge clk);
    period_end = pe; btn_up = up; btn_dn = dn;
    breathe = g_breathe; limit = g_limit[WIDTH-1:0];
    if (up && !prev_up) arr_up[cyc + 2] = 1'b1;
    if (dn && !prev_dn) arr_dn[cyc + 2] = 1'b1;
    prev_up = up; prev_dn = dn;
    model_step(pe, arr_up.exists(cyc), arr_dn.exists(cyc));
    cyc++;
  endtask

  task automatic period(input int len, input int rate);
    for (int i = 0; i < len; i++) begin
      bit u, d;
      u = (rate > 0) && ($urandom_range(rate - 1) == 0);
      d = (rate > 0) && ($urandom_range(rate - 1) == 0);
      tick(i == len - 1, u, d);
    end
  endtask

  task automatic period_press(input int len, input int pos, input bit u, input bit d);
    for (int i = 0; i < len; i++) tick(i == len - 1, (i == pos) && u, (i == pos) && d);
  endtask

  // Run breathing periods until the model sits at DUTY=3 in RAMP_UP.
  task automatic seek_ramp3();
    int guard = 0;
    while (!(m_state == 1 && m_duty == 3) && guard < 80) begin
      period(3, 4);
      guard++;
    end
    n_vec++;
    if (!(m_state == 1 && m_duty == 3)) begin
      n_err++;
      $display("FAIL seek_ramp3: got state=%0d duty=%0d after %0d periods, want state=1 duty=3",
               m_state, m_duty, guard);
    end
  endtask

  task automatic async_reset_check();
    exp_t z;
    z = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", z);
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t cur;
    bit   pe_s;
    cur = '0;
    forever begin
      @(posedge clk);
      pe_s = period_end;
      #1;
      if (!rst_n) cur = '0;
      else if (pe_s) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scoreboard_empty @%0t: got duty=%0d, want a queued expectation", $time, duty);
        end else begin
          cur = exp_q.pop_front();
          $display("pe @%0t: duty=%0d state=%0d dir=%0d limit=%0d breathe=%0d",
                   $time, duty, state, ramp_dir, limit, breathe);
        end
      end
      check(pe_s ? "pe_update" : "steady", cur);
    end
  end

  initial begin : driver
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Manual stepping with LIMIT=5: saturate up, then down to 0 without wrap.
    g_limit = 5;
    for (int k = 0; k < 10; k++) period_press(6, 0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)  period_press(6, 0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++)  period_press(6, 0, 1'b1, 1'b0);

    // Clamp: LIMIT drops below DUTY mid-period.
    period(2, 0);
    g_limit = 2;
    period(6, 0);
    g_limit = 5;

    // Edge timing relative to PERIOD_END, and simultaneous presses.
    period_press(6, 1, 1'b1, 1'b0);
    period_press(6, 3, 1'b1, 1'b0);
    period(6, 0);
    period_press(6, 0, 1'b1, 1'b1);
    period_press(6, 3, 1'b0, 1'b1);
    period(6, 0);

    // Random manual traffic with occasional LIMIT changes.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0) g_limit = $urandom_range(12);
      period($urandom_range(8, 1), 3);
    end

    // Breathing at LIMIT=5; button traffic must be ignored.
    g_limit = 5;
    g_breathe = 1'b1;
    for (int k = 0; k < 60; k++) period(3, 4);

    // Mode exit at DUTY=3 in RAMP_UP with a press queued while in auto.
    seek_ramp3();
    g_breathe = 1'b0;
    period_press(5, 0, 1'b1, 1'b0);
    period(5, 0);
    period(5, 0);

    // Asynchronous reset mid-ramp.
    g_breathe = 1'b1;
    seek_ramp3();
    async_reset_check();

    // LIMIT=0 while breathing: DUTY pinned at 0, FSM still cycles.
    g_limit = 0;
    for (int k = 0; k < 20; k++) period(2, 0);

    // Mixed random traffic, including the full-scale LIMIT.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(3) == 0) g_limit = ($urandom_range(9) == 0) ? 255 : $urandom_range(15);
      if ($urandom_range(7) == 0) g_breathe = ~g_breathe;
      period($urandom_range(8, 1), 3);
    end

    g_breathe = 1'b0;
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Upstream stage of the PWM output path. Generates the registered duty/compare value that drives the comparator's threshold input, replacing the hard-wired constant/mux feed. Supports manual step control from two push-buttons and an automatic "breathing" ramp. DUTY updates only on PWM period boundaries, so no PWM period ever sees a glitched threshold.

Parameters:
WIDTH, 8, width of LIMIT and DUTY; must match the PWM counter width
STEP, 1, DUTY increment/decrement per step
PERIODS_PER_STEP, 2, PWM periods between auto-ramp steps (>=1)
HOLD_PERIODS, 4, PWM periods dwelt at each ramp extreme (used only with HOLD_STATES_EN)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  reset; asynchronous assert, active-low
PERIOD_END  in  1  one-CLK pulse from the PWM counter on wrap to 0
LIMIT  in  WIDTH  counter terminal value; maximum legal DUTY
BTN_UP  in  1  raw asynchronous button, step duty up
BTN_DN  in  1  raw asynchronous button, step duty down
BREATHE  in  1  level; 1 = auto ramp, 0 = manual
DUTY  out  WIDTH  registered threshold to the comparator
RAMP_DIR  out  1  1 in RAMP_UP/HOLD_HI, else 0
STATE  out  3  FSM state encoding, for debug

Behaviour:
- Reset (RST_N=0, async): DUTY=0, RAMP_DIR=0, STATE=MANUAL, step/hold counter=0, pending request cleared, synchronizer flops=0.
- Buttons: 2-FF synchronizer, then rising-edge detect. An edge is registered 3 CLK edges after the raw rise.
- Pending request register: UP edge sets pending=+1, DN edge sets pending=-1. The last edge wins. UP and DN edges in the same cycle are both ignored and leave the existing pending value unchanged.
- DUTY is written only on a CLK edge where PERIOD_END=1; it is never written elsewhere. An edge that coincides with PERIOD_END becomes pending and is applied at the following PERIOD_END.
- Arithmetic is done in WIDTH+1 bits:
  - up: DUTY = min(DUTY+STEP, LIMIT)
  - down: DUTY = max(DUTY-STEP, 0)
  - no wrap-around in either direction.
- Clamp: if LIMIT < DUTY at any PERIOD_END, DUTY=LIMIT. The clamp takes priority over any step in that same period.
- FSM states: MANUAL=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4. All transitions are evaluated only at PERIOD_END.
  - MANUAL: applies the pending request, then clears it. BREATHE=1 -> RAMP_UP.
  - Any auto state with BREATHE=0 -> MANUAL. DUTY is retained and the pending request is cleared.
  - RAMP_UP: each PERIODS_PER_STEP-th PERIOD_END, DUTY += STEP (saturating). When the new DUTY == LIMIT -> HOLD_HI.
  - HOLD_HI: after HOLD_PERIODS PERIOD_ENDs -> RAMP_DN.
  - RAMP_DN: mirror of RAMP_UP; DUTY reaching 0 -> HOLD_LO.
  - HOLD_LO: after HOLD_PERIODS PERIOD_ENDs -> RAMP_UP.
  - Button edges are discarded in the auto states.
  - The period counter resets to 0 on every state change.
- LIMIT=0: DUTY stays 0. The auto FSM still cycles, moving RAMP_UP->HOLD_HI on its first step tick.
- STATE encodings not listed above -> MANUAL on the next CLK.

Optional Feature:
HOLD_STATES_EN
- Defined: HOLD_HI/HOLD_LO dwell states exist exactly as described in Behaviour.
- Undefined: no dwell states. RAMP_UP reaching LIMIT goes directly to RAMP_DN, and RAMP_DN reaching 0 goes directly to RAMP_UP, at that same PERIOD_END. The HOLD_PERIODS parameter is unused. STATE never shows 2 or 4.

Test Plan:
1. Reset: RST_N low mid-ramp with DUTY=3 -> DUTY=0, STATE=0, RAMP_DIR=0 immediately, without waiting for a CLK edge.
2. Manual step, LIMIT=5, BREATHE=0: 3 BTN_UP presses, each in a separate period -> DUTY 1,2,3, each change exactly 1 CLK after a PERIOD_END. 7 more presses -> DUTY saturates at 5. 6 BTN_DN presses -> DUTY reaches 0, then holds at 0 with no wrap to 255.
3. Glitch-free: BTN_UP edge 2 cycles before PERIOD_END -> DUTY constant until the PERIOD_END edge. Edge coincident with PERIOD_END -> applied one period later. Simultaneous UP+DN -> no change.
4. Clamp: DUTY=5, then LIMIT changed to 2 -> DUTY=2 at the next PERIOD_END, not before.
5. Breathing, LIMIT=5, STEP=1, PERIODS_PER_STEP=2, HOLD_PERIODS=4, HOLD_STATES_EN defined:
   - DUTY 0->5 over 10 PERIOD_ENDs.
   - STATE 1->2; held for 4 periods; then STATE 3.
   - DUTY 5->0 over 10 periods; STATE 4.
   - RAMP_DIR tracks the states.
   - Repeat without HOLD_STATES_EN -> direct 1->3->1 reversal.
6. Mode exit: BREATHE drops with DUTY=3 in RAMP_UP -> STATE=0 at the next PERIOD_END, DUTY stays 3, and a button press queued during auto mode has no effect.
